pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
- Multicycle fetch/issue/execute sequencer for the 32-bit program counter (byte addresses, 4-byte instructions).
- Generates the PC control strobes and data:
  - `pc_data_in`
  - `pc_write_enable`
  - `pc_write_add`
  - `pc_count_enable`
- Fetches from instruction memory over a req/ready handshake and issues one instruction at a time to decode over a valid/ready handshake.
- Waits for execute completion, then applies a branch, jump or trap redirect.
- Sits between the PC register, instruction memory and the decode/execute stages of the single-issue core.

Parameters:
- RESET_VECTOR, 32'h0000_0000, PC value loaded on boot.
- TRAP_VECTOR, 32'h0000_0100, PC value loaded on trap or memory timeout.
- MEM_TIMEOUT, 16, max cycles in FETCH without `imem_ready` before a fault (range 1..255).

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `pc_value` in 32: current PC (PC register output).
- `pc_data_in` out 32: data to PC.
- `pc_write_enable` out 1: PC write strobe.
- `pc_write_add` out 1: 1 = relative write, PC <= PC + data - 4; 0 = absolute write.
- `pc_count_enable` out 1: PC <= PC + 4.
- `imem_req` out 1: fetch request.
- `imem_addr` out 32: fetch address.
- `imem_ready` in 1: fetch data valid.
- `imem_rdata` in 32: fetched instruction.
- `instr` out 32: held instruction to decode.
- `instr_valid` out 1: instruction offered.
- `instr_ready` in 1: decode accepts.
- `exec_done` in 1: execute finished the issued instruction.
- `exec_redirect` in 1: with `exec_done`, redirect the PC.
- `exec_rel` in 1: redirect is a relative offset (1) or an absolute target (0).
- `exec_target` in 32: offset or target.
- `trap` in 1: with `exec_done`, exception raised; highest priority.
- `halt_req` in 1: stop after the current instruction.
- `start` in 1: leave HALT.
- `halted` out 1: in HALT.
- `mem_fault` out 1: sticky, fetch timed out.

Behaviour:
- States: BOOT, FETCH, ISSUE, EXEC, HALT. Registered state with combinational output decode; `instr`, the watchdog count and `mem_fault` are registered.
- Reset (`reset` low, any time including mid-fetch or mid-issue):
  - State = BOOT; `instr` = 0; watchdog = 0; `mem_fault` = 0.
  - Outputs decode BOOT: `pc_write_enable` = 1, `pc_write_add` = 0, `pc_data_in` = RESET_VECTOR.
  - All other outputs are 0.
- BOOT:
  - Drives the absolute load of RESET_VECTOR.
  - Next state is HALT if `halt_req` = 1, else FETCH.
- FETCH:
  - `imem_req` = 1; `imem_addr` = `pc_value`; the watchdog increments each cycle.
  - `imem_ready` = 1: capture `imem_rdata` into `instr`, clear the watchdog, go to ISSUE. Zero-wait memory costs 1 cycle.
  - Watchdog reaches MEM_TIMEOUT with no ready: that cycle drives an absolute load of TRAP_VECTOR, sets `mem_fault`, clears the watchdog, and stays in FETCH.
  - `imem_ready` in the timeout cycle wins: the data is taken and no fault is raised.
- ISSUE:
  - `instr_valid` = 1; `instr` is stable.
  - On `instr_ready`, `pc_count_enable` = 1 for exactly that cycle and the state goes to EXEC.
  - The PC therefore holds the instruction address + 4 during EXEC.
- EXEC: waits for `exec_done`. On `exec_done`, priority is:
  1. `trap`: absolute load of TRAP_VECTOR.
  2. `exec_redirect`: `pc_write_enable` = 1, `pc_write_add` = `exec_rel`, `pc_data_in` = `exec_target`.
  3. Neither: no PC write.
- Relative redirect: the PC unit's built-in -4 cancels the ISSUE increment, so new PC = instruction address + offset (signed, modulo 2^32).
- After `exec_done`: next state is HALT if `halt_req` = 1, else FETCH. The redirect or trap is still applied in the same cycle.
- HALT:
  - `halted` = 1; no strobes asserted.
  - `start` = 1 goes to FETCH. `start` and `halt_req` both high: `start` wins.
- Ignored inputs: `exec_done`/`trap` outside EXEC, `imem_ready` outside FETCH, `instr_ready` outside ISSUE.
- Strobe exclusivity:
  - `pc_write_enable` and `pc_count_enable` are never high in the same cycle.
  - At most one PC strobe per instruction, plus the redirect.
- Minimum loop, no redirect: FETCH → ISSUE → EXEC = 3 cycles per instruction with zero-wait handshakes.
- Wrap-around: the PC add wraps modulo 2^32. The sequencer does not check alignment.

Decomposition:
- Package `pc_seq_pkg`:
  - State enum: BOOT, FETCH, ISSUE, EXEC, HALT.
  - Instruction width (32) and step (4).
  - Default RESET_VECTOR and TRAP_VECTOR.
- Sub-module `fetch_watchdog`:
  - Counter with clear/enable and a `expired` output at MEM_TIMEOUT.
  - Width = $clog2(MEM_TIMEOUT+1); asynchronous active-low reset.
- Rest is a single FSM module.

Test Plan:
- Boot: release `reset`, `imem_ready` tied 1, `instr_ready` 1, `exec_done` 1 every EXEC.
  - Required: first `imem_addr` = 0x0, then 0x4, 0x8.
  - `pc_count_enable` pulses once per instruction; 3 cycles per instruction.
- Relative branch: instruction at 0x10; EXEC returns redirect, rel = 1, target = 0xFFFF_FFF8 (-8).
  - Required: next `imem_addr` = 0x08.
  - Absolute target 0x200 → next `imem_addr` = 0x200.
- Trap priority: `exec_done`, `trap` and `exec_redirect` (target 0x40) all high in one cycle.
  - Required: PC loads 0x100; next fetch at 0x100.
- Timeout: `imem_ready` held 0 with MEM_TIMEOUT = 16.
  - Required: on the 16th FETCH cycle, absolute write of 0x100 and `mem_fault` = 1 (sticky).
  - Then ready returns → fetch at 0x100.
- Stalls and halt:
  - `instr_ready` low for 5 cycles: `instr` stable, no `pc_count_enable` until accept.
  - `halt_req` with `exec_done`: `halted` = 1 next cycle.
  - `start` pulse: fetch resumes at PC + 4.
- Async reset asserted mid-ISSUE:
  - Required: `instr_valid` drops to 0 immediately.
  - On release, boot load of 0x0 and fetch at 0x0.

Source files
------------

// File: rtl/pc_seq_pkg.sv
// Shared constants and state encoding for the program-counter sequencer.
// The state constants double as the debug-state enum values.
package pc_seq_pkg;

    localparam int          INSTR_WIDTH          = 32;
    localparam logic [31:0] INSTR_STEP           = 32'd4;
    localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_TRAP_VECTOR  = 32'h0000_0100;

    localparam logic [2:0] ST_BOOT  = 3'd0;
    localparam logic [2:0] ST_FETCH = 3'd1;
    localparam logic [2:0] ST_ISSUE = 3'd2;
    localparam logic [2:0] ST_EXEC  = 3'd3;
    localparam logic [2:0] ST_HALT  = 3'd4;

    typedef enum logic [2:0] {
        BOOT  = ST_BOOT,
        FETCH = ST_FETCH,
        ISSUE = ST_ISSUE,
        EXEC  = ST_EXEC,
        HALT  = ST_HALT
    } seqState_e;

endpackage

// File: rtl/fetch_watchdog.sv
// Counts consecutive FETCH cycles without memory response; expired marks the
// cycle in which the count reaches MEM_TIMEOUT.
module fetch_watchdog #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int W = $clog2(MEM_TIMEOUT + 1);

    logic [W-1:0] count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 1'b1;
        end
    end

    // The current cycle is the MEM_TIMEOUT-th one when the count already holds MEM_TIMEOUT-1.
    assign expired = enable && (count == W'(MEM_TIMEOUT - 1));

endmodule

// File: rtl/pc_sequencer.sv
// Multicycle fetch/issue/execute sequencer driving the PC register strobes,
// the instruction-memory request and the decode hand-off.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR,
    parameter logic [31:0] TRAP_VECTOR  = DEFAULT_TRAP_VECTOR,
    parameter int          MEM_TIMEOUT  = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc_value,
    output logic [31:0] pc_data_in,
    output logic        pc_write_enable,
    output logic        pc_write_add,
    output logic        pc_count_enable,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        exec_done,
    input  logic        exec_redirect,
    input  logic        exec_rel,
    input  logic [31:0] exec_target,
    input  logic        trap,
    input  logic        halt_req,
    input  logic        start,
    output logic        halted,
    output logic        mem_fault,
    output seqState_e   stateDbg
);

    logic [2:0] stateQ;
    logic [2:0] stateNext;
    logic       wdClear;
    logic       wdEnable;
    logic       wdExpired;
    logic       captureInstr;
    logic       setFault;

    fetch_watchdog #(
        .MEM_TIMEOUT(MEM_TIMEOUT)
    ) uWatchdog (
        .clk    (clk),
        .reset  (reset),
        .clear  (wdClear),
        .enable (wdEnable),
        .expired(wdExpired)
    );

    // Handshakes: a transfer happens in a cycle where both sides are high
    // (imem_req & imem_ready, instr_valid & instr_ready); the offering side
    // keeps its request and data steady until that cycle.
    always_comb begin
        stateNext       = stateQ;
        pc_data_in      = '0;
        pc_write_enable = 1'b0;
        pc_write_add    = 1'b0;
        pc_count_enable = 1'b0;
        imem_req        = 1'b0;
        imem_addr       = '0;
        instr_valid     = 1'b0;
        halted          = 1'b0;
        wdClear         = 1'b1;
        wdEnable        = 1'b0;
        captureInstr    = 1'b0;
        setFault        = 1'b0;
        case (stateQ)
            ST_BOOT: begin
                pc_write_enable = 1'b1;
                pc_data_in      = RESET_VECTOR;
                stateNext       = halt_req ? ST_HALT : ST_FETCH;
            end
            ST_FETCH: begin
                imem_req  = 1'b1;
                imem_addr = pc_value;
                wdEnable  = 1'b1;
                wdClear   = 1'b0;
                if (imem_ready) begin
                    captureInstr = 1'b1;
                    wdClear      = 1'b1;
                    stateNext    = ST_ISSUE;
                end else if (wdExpired) begin
                    pc_write_enable = 1'b1;
                    pc_data_in      = TRAP_VECTOR;
                    setFault        = 1'b1;
                    wdClear         = 1'b1;
                end
            end
            ST_ISSUE: begin
                instr_valid = 1'b1;
                if (instr_ready) begin
                    pc_count_enable = 1'b1;
                    stateNext       = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (exec_done) begin
                    if (trap) begin
                        pc_write_enable = 1'b1;
                        pc_data_in      = TRAP_VECTOR;
                    end else if (exec_redirect) begin
                        pc_write_enable = 1'b1;
                        pc_write_add    = exec_rel;
                        pc_data_in      = exec_target;
                    end
                    stateNext = halt_req ? ST_HALT : ST_FETCH;
                end
            end
            ST_HALT: begin
                halted = 1'b1;
                if (start) begin
                    stateNext = ST_FETCH;
                end
            end
            default: begin
                stateNext = ST_BOOT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stateQ    <= ST_BOOT;
            instr     <= '0;
            mem_fault <= 1'b0;
        end else begin
            stateQ <= stateNext;
            if (captureInstr) begin
                instr <= imem_rdata;
            end
            if (setFault) begin
                mem_fault <= 1'b1;
            end
        end
    end

    assign stateDbg = seqState_e'(stateQ);

endmodule

// File: tb/tb_pc_sequencer.sv
// Randomized bench for pc_sequencer: drives memory, decode and execute,
// models the PC register, and scores fetch addresses and issued instructions.
module tb_pc_sequencer;
    import pc_seq_pkg::*;

    localparam int          T     = 16;
    localparam logic [31:0] RST_V = 32'h0000_0000;
    localparam logic [31:0] TRP_V = 32'h0000_0100;

    logic        clk;
    logic        reset;
    logic [31:0] pc_value = 32'hDEAD_BEE0;
    logic [31:0] pc_data_in;
    logic        pc_write_enable;
    logic        pc_write_add;
    logic        pc_count_enable;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic        exec_done;
    logic        exec_redirect;
    logic        exec_rel;
    logic [31:0] exec_target;
    logic        trap;
    logic        halt_req;
    logic        start;
    logic        halted;
    logic        mem_fault;
    seqState_e   stateDbg;

    pc_sequencer #(
        .RESET_VECTOR(RST_V),
        .TRAP_VECTOR (TRP_V),
        .MEM_TIMEOUT (T)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .pc_value       (pc_value),
        .pc_data_in     (pc_data_in),
        .pc_write_enable(pc_write_enable),
        .pc_write_add   (pc_write_add),
        .pc_count_enable(pc_count_enable),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ready     (imem_ready),
        .imem_rdata     (imem_rdata),
        .instr          (instr),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .exec_done      (exec_done),
        .exec_redirect  (exec_redirect),
        .exec_rel       (exec_rel),
        .exec_target    (exec_target),
        .trap           (trap),
        .halt_req       (halt_req),
        .start          (start),
        .halted         (halted),
        .mem_fault      (mem_fault),
        .stateDbg       (stateDbg)
    );

    // ---------------- clock / PC register environment ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (pc_write_enable)
            pc_value <= pc_write_add ? (pc_value + pc_data_in - 32'd4) : pc_data_in;
        else if (pc_count_enable)
            pc_value <= pc_value + 32'd4;
    end

    // ---------------- scoreboard state ----------------
    logic [31:0] exp_addr_q[$];
    logic [31:0] exp_instr_q[$];
    logic        exp_fault_q[$];
    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] model_pc;
    logic        model_fault;
    int          cyc = 0;
    int          ce_count = 0;
    int          acc_n = 0;
    int          acc_cyc[3];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (reset) begin
            if (imem_req && imem_ready) begin
                if (acc_n < 3) begin
                    acc_cyc[acc_n] = cyc;
                    acc_n++;
                end
                if (exp_addr_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_fetch: got fetch at 0x%08h, expected none", imem_addr);
                end else begin
                    chk("fetch_addr", imem_addr, exp_addr_q.pop_front());
                    chk("mem_fault", {31'b0, mem_fault}, {31'b0, exp_fault_q.pop_front()});
                end
            end
            if (instr_valid && instr_ready) begin
                if (exp_instr_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_issue: got instr 0x%08h, expected none", instr);
                end else begin
                    chk("issued_instr", instr, exp_instr_q.pop_front());
                end
            end
            if (pc_count_enable) ce_count++;
            if (pc_write_enable || pc_count_enable)
                chk("strobe_exclusive", {31'b0, pc_write_enable && pc_count_enable}, 32'd0);
            if (pc_count_enable || (instr_valid && instr_ready))
                chk("count_on_accept", {31'b0, pc_count_enable}, {31'b0, instr_valid && instr_ready});
        end
    end

    // ---------------- driver tasks ----------------
    task automatic clear_inputs();
        imem_ready    = 1'b0;
        imem_rdata    = '0;
        instr_ready   = 1'b0;
        exec_done     = 1'b0;
        exec_redirect = 1'b0;
        exec_rel      = 1'b0;
        exec_target   = '0;
        trap          = 1'b0;
        halt_req      = 1'b0;
        start         = 1'b0;
    endtask

    // Entered at posedge+1 with the sequencer in FETCH; returns at posedge+1 in FETCH.
    task automatic run_instr(input int w, input int stall, input int exec_wait,
                             input logic trp, input logic redir, input logic rel,
                             input logic [31:0] tgt, input logic hlt);
        logic [31:0] data;
        logic [31:0] faddr;
        data  = $urandom();
        faddr = (w >= T) ? TRP_V : model_pc;
        if (w >= T) model_fault = 1'b1;
        exp_addr_q.push_back(faddr);
        exp_fault_q.push_back(model_fault);
        exp_instr_q.push_back(data);

        for (int c = 0; c < w; c++) begin
            imem_ready  = 1'b0;
            imem_rdata  = $urandom();
            instr_ready = 1'($urandom_range(0, 1));
            exec_done   = 1'($urandom_range(0, 1));
            trap        = 1'($urandom_range(0, 1));
            if (c == T - 2) begin
                @(negedge clk);
                chk("pre_timeout_we", {31'b0, pc_write_enable}, 32'd0);
            end
            if (c == T - 1) begin
                @(negedge clk);
                chk("timeout_we", {31'b0, pc_write_enable}, 32'd1);
                chk("timeout_add", {31'b0, pc_write_add}, 32'd0);
                chk("timeout_data", pc_data_in, TRP_V);
            end
            @(posedge clk); #1;
        end
        imem_ready = 1'b1;
        imem_rdata = data;
        if (w == T - 1) begin
            @(negedge clk);
            chk("ready_wins_we", {31'b0, pc_write_enable}, 32'd0);
        end
        @(posedge clk); #1;
        imem_ready = 1'b0;
        imem_rdata = $urandom();

        for (int s = 0; s < stall; s++) begin
            instr_ready = 1'b0;
            exec_done   = 1'($urandom_range(0, 1));
            trap        = 1'($urandom_range(0, 1));
            @(negedge clk);
            chk("stall_instr", instr, data);
            chk("stall_count_en", {31'b0, pc_count_enable}, 32'd0);
            @(posedge clk); #1;
        end
        instr_ready = 1'b1;
        @(posedge clk); #1;
        instr_ready = 1'b0;
        exec_done   = 1'b0;
        trap        = 1'b0;

        for (int e = 0; e < exec_wait; e++) begin
            imem_ready  = 1'($urandom_range(0, 1));
            instr_ready = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
        end
        exec_done     = 1'b1;
        trap          = trp;
        exec_redirect = redir;
        exec_rel      = rel;
        exec_target   = tgt;
        halt_req      = hlt;
        @(posedge clk); #1;
        clear_inputs();

        if (trp)        model_pc = TRP_V;
        else if (redir) model_pc = rel ? (faddr + tgt) : tgt;
        else            model_pc = faddr + 32'd4;

        if (hlt) begin
            @(negedge clk);
            chk("halted_after_exec", {31'b0, halted}, 32'd1);
            for (int h = 0; h < int'($urandom_range(1, 4)); h++) begin
                @(posedge clk); #1;
                halt_req   = 1'($urandom_range(0, 1));
                imem_ready = 1'($urandom_range(0, 1));
                @(negedge clk);
                chk("halt_hold", {31'b0, halted}, 32'd1);
            end
            @(posedge clk); #1;
            imem_ready = 1'b0;
            start      = 1'b1;
            halt_req   = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            start    = 1'b0;
            halt_req = 1'b0;
        end
    endtask

    task automatic run_random();
        int          w;
        int          k;
        logic        trp;
        logic        redir;
        logic        rel;
        logic [31:0] tgt;
        w = ($urandom_range(0, 9) == 0) ? int'($urandom_range(T - 1, T + 18)) : int'($urandom_range(0, 3));
        k = $urandom_range(0, 7);
        trp   = (k == 0);
        redir = (k <= 3) ? 1'b1 : 1'b0;
        rel   = 1'($urandom_range(0, 1));
        if (rel && $urandom_range(0, 3) != 0) tgt = (32'($urandom_range(0, 64)) << 2) - 32'd128;
        else                                   tgt = $urandom();
        run_instr(w, $urandom_range(0, 3), $urandom_range(0, 3), trp, redir, rel, tgt,
                  $urandom_range(0, 9) == 0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        clear_inputs();
        reset = 1'b0;
        model_pc    = RST_V;
        model_fault = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_state", 32'(stateDbg), 32'(BOOT));
        chk("reset_we", {31'b0, pc_write_enable}, 32'd1);
        chk("reset_add", {31'b0, pc_write_add}, 32'd0);
        chk("reset_data", pc_data_in, RST_V);
        chk("reset_req", {31'b0, imem_req}, 32'd0);
        chk("reset_valid", {31'b0, instr_valid}, 32'd0);
        chk("reset_instr", instr, 32'd0);
        chk("reset_fault", {31'b0, mem_fault}, 32'd0);
        chk("reset_halted", {31'b0, halted}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;

        // Zero-wait boot loop: 0x0, 0x4, 0x8
        for (int i = 0; i < 3; i++) run_instr(0, 0, 0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
        chk("boot_count_pulses", ce_count, 32'd3);
        chk("boot_gap_a", acc_cyc[1] - acc_cyc[0], 32'd3);
        chk("boot_gap_b", acc_cyc[2] - acc_cyc[1], 32'd3);

        run_instr(0, 0, 0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);          // 0xC
        run_instr(0, 0, 0, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFF8, 1'b0);  // 0x10 -> 0x08
        run_instr(0, 0, 1, 1'b0, 1'b1, 1'b0, 32'h0000_0200, 1'b0);  // 0x08 -> 0x200
        run_instr(0, 0, 0, 1'b1, 1'b1, 1'b0, 32'h0000_0040, 1'b0);  // trap wins -> 0x100
        run_instr(T + 4, 0, 0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);      // timeout -> 0x100, fault
        run_instr(0, 5, 0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);          // decode stall
        run_instr(0, 0, 0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1);          // halt, resume at PC+4
        run_instr(T - 1, 0, 0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);      // ready in timeout cycle

        for (int i = 0; i < 120; i++) run_random();

        // Asynchronous reset while an instruction is being offered
        exp_addr_q.push_back(model_pc);
        exp_fault_q.push_back(model_fault);
        imem_ready = 1'b1;
        imem_rdata = $urandom();
        @(posedge clk); #1;
        imem_ready = 1'b0;
        @(negedge clk);
        chk("issue_valid", {31'b0, instr_valid}, 32'd1);
        #1;
        reset = 1'b0;
        #1;
        chk("async_valid", {31'b0, instr_valid}, 32'd0);
        chk("async_we", {31'b0, pc_write_enable}, 32'd1);
        chk("async_data", pc_data_in, RST_V);
        chk("async_instr", instr, 32'd0);
        chk("async_fault", {31'b0, mem_fault}, 32'd0);
        model_pc    = RST_V;
        model_fault = 1'b0;
        @(posedge clk); #1;
        halt_req = 1'b1;
        reset    = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("boot_to_halt", {31'b0, halted}, 32'd1);
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start    = 1'b0;
        halt_req = 1'b0;
        for (int i = 0; i < 20; i++) run_random();

        repeat (3) @(posedge clk);
        chk("addr_q_drained", exp_addr_q.size(), 32'd0);
        chk("instr_q_drained", exp_instr_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
